// File: rtl/fifo_burst_reader.sv
`timescale 1ns/1ps
// Drains a 16-entry show-ahead FIFO into framed valid/ready bursts (m_sop/m_eop).
// Define FLUSH_TIMEOUT_EN to flush short bursts after TIMEOUT idle cycles.
module fifo_burst_reader #(
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic [3:0]        fifo_usedw,
  output logic              fifo_rdreq,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sop,
  output logic              m_eop,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  localparam logic [4:0]       BL5      = 5'(BURST_LEN);
  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
    $error("fifo_burst_reader: BURST_LEN must be in 1..16");
  end
  if (GAP_CYCLES < 0 || TIMEOUT < 0) begin : g_bad_counts
    $error("fifo_burst_reader: GAP_CYCLES and TIMEOUT must be non-negative");
  end

  state_t           state, state_nxt;
  logic [4:0]       level;
  logic [4:0]       remaining;
  logic [GAP_W-1:0] gap_cnt;
  logic             sop_pending;
  logic             out_free;
  logic             pop;
  logic             start_full;
  logic             flush_cond;
  logic             flush_fire;

  // usedw wraps to 0 at 16 entries, so the full flag supplies the top bit
  assign level      = fifo_full ? 5'd16 : {1'b0, fifo_usedw};
  assign out_free   = ~m_valid | m_ready;
  assign start_full = enable & (level >= BL5);
  assign flush_cond = enable & ~fifo_empty & (level < BL5);
  assign pop        = fifo_rdreq;

`ifdef FLUSH_TIMEOUT_EN
  localparam int            TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt;

  assign flush_fire = (TIMEOUT != 0) & flush_cond & (to_cnt == TO_MAX);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == IDLE && state_nxt == IDLE && flush_cond) begin
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign flush_fire = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_full || flush_fire) state_nxt = BURST;
      BURST: if ((pop && remaining == 5'd1) || remaining == 5'd0)
               state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:   if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_rdreq = rst_n & (state == BURST) & ~fifo_empty & (remaining != 5'd0) & out_free;
    busy       = (state != IDLE) | m_valid;
  end

  // Burst length is latched on entry; a flush takes whatever level was present then
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      remaining   <= 5'd0;
      sop_pending <= 1'b0;
    end else if (state == IDLE) begin
      if (start_full) begin
        remaining   <= BL5;
        sop_pending <= 1'b1;
      end else if (flush_fire) begin
        remaining   <= level;
        sop_pending <= 1'b1;
      end
    end else if (pop) begin
      remaining   <= remaining - 5'd1;
      sop_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                                gap_cnt <= '0;
    else if (state != GAP)                     gap_cnt <= '0;
    else if (gap_cnt != GAP_LAST)              gap_cnt <= gap_cnt + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
    end else if (out_free) begin
      m_valid <= pop;
      if (pop) begin
        m_data <= fifo_q;
        m_sop  <= sop_pending;
        m_eop  <= (remaining == 5'd1);
      end else begin
        m_sop  <= 1'b0;
        m_eop  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Drain-side controller for the team's 16-entry synchronous FIFO.
- Pops words through the FIFO read port (rdreq / show-ahead q / empty / full / usedw).
- Emits them as framed bursts on a valid/ready stream, marking the first word with m_sop and the last with m_eop.
- Starts a burst once BURST_LEN words are buffered; optionally flushes a short burst after an idle timeout.

Parameters:
- DATA_W, 8: word width; equals FIFO data width.
- BURST_LEN, 8: words per full burst; legal range 1..16.
- GAP_CYCLES, 2: idle cycles forced between bursts; 0 allowed.
- TIMEOUT, 64: cycles a non-empty, sub-threshold FIFO waits before a flush burst; 0 disables; used only with FLUSH_TIMEOUT_EN.

Ports:
- clk_in  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  high permits new bursts; a burst in progress always completes.
- fifo_q  in  DATA_W  FIFO head word, show-ahead (valid combinationally while fifo_empty=0).
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_usedw  in  4  FIFO fill count (reads 0 when full).
- fifo_rdreq  out  1  pop request; combinational.
- m_data  out  DATA_W  output word, registered.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_sop  out  1  first word of burst; qualified by m_valid.
- m_eop  out  1  last word of burst; qualified by m_valid.
- busy  out  1  state != IDLE or m_valid=1.

Behaviour:
- Reset: async. All of the following clear immediately: state=IDLE, m_valid=0, m_data=0, m_sop=0, m_eop=0, remaining=0, gap and timeout counters=0, busy=0. fifo_rdreq=0 while rst_n=0.
- Reset mid-burst: the burst is abandoned with no m_eop. Words already popped are lost.
- level (5 bits) = fifo_full ? 16 : {1'b0, fifo_usedw}.
- Output register is free when m_valid=0 or m_ready=1 (pass-through on a consumed cycle).
- fifo_rdreq = (state==BURST) & ~fifo_empty & (remaining != 0) & out_free.
- Read safety never relies on usedw.
- Pop latency: the word on fifo_q at a cycle with fifo_rdreq=1 appears on m_data with m_valid=1 at the next edge.
- Throughput: 1 word/cycle when m_ready is held high.
- When out_free=1 and no pop occurs, m_valid falls to 0 at the next edge.
- m_valid, once high, holds m_data/m_sop/m_eop stable until m_ready=1.
- States:
  - IDLE: if enable & level>=BURST_LEN, go to BURST with remaining=BURST_LEN. Else, if a flush condition fires (see Optional Feature), go to BURST with remaining=level, latched at entry.
  - BURST: each pop decrements remaining. The first pop of a burst sets m_sop; the pop that brings remaining to 0 sets m_eop. A single-word burst carries both flags.
  - BURST stall: if fifo_empty rises before remaining=0, stay in BURST with rdreq=0. No eop and no timeout apply.
  - BURST exit: after the last pop, go to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
  - GAP: count GAP_CYCLES cycles, then go to IDLE. The gap counts from the last pop, independent of m_ready.
- A new burst may start while the previous eop word is still held in the output register. Ordering is preserved because pops require out_free.
- enable falling mid-burst: no effect until the burst ends; IDLE then holds.
- Arithmetic: remaining is 5 bits. Counters saturate and never wrap. The BURST_LEN range is checked at elaboration, out of range = error.

Optional Feature:
- Macro: FLUSH_TIMEOUT_EN.
- Defined:
  - A timeout counter increments in IDLE while enable=1, fifo_empty=0 and level<BURST_LEN.
  - It clears on leaving IDLE, or when fifo_empty=1 or enable=0.
  - When it reaches TIMEOUT (TIMEOUT!=0), a flush burst of remaining=level words starts on the next edge.
- Undefined:
  - No counter logic is built; TIMEOUT is ignored.
  - Bursts start only on level>=BURST_LEN, so sub-threshold data waits indefinitely.

Test Plan:
- Reset with m_ready=1, then write 8 words 0x10..0x17: 1 cycle after level=8, fifo_rdreq is high for 8 consecutive cycles. m_data = 0x10..0x17 on consecutive cycles, m_sop with 0x10, m_eop with 0x17. Then 2 GAP cycles with fifo_rdreq=0.
- Same 8 words with m_ready toggling 1,0,1,0: no word is lost or duplicated, m_data is held stable while m_ready=0, and fifo_rdreq never pops while the output register is full.
- Fill the FIFO to 16 (usedw=0, full=1) with BURST_LEN=16: exactly 16 pops, m_eop on the 16th word, FIFO empty afterwards.
- FLUSH_TIMEOUT_EN, TIMEOUT=64, write 3 words 0xA0..0xA2 then stop: no rdreq for 64 cycles. Then a 3-word burst with m_sop on 0xA0 and m_eop on 0xA2. Without the macro, no pop ever occurs.
- Pulse rst_n low after the 4th word of an 8-word burst: m_valid=0 and fifo_rdreq=0 immediately. After release, state=IDLE and no m_eop appears.
- Hold enable=0 with 10 words buffered: no pops. Raise enable: one 8-word burst, then the remaining 2 words wait (or flush under FLUSH_TIMEOUT_EN).
